// File: rtl/err_event_log_if.sv
// Ports of the error event logger: per-channel event strobes, FIFO read port
// and drop status. The logger is the slave; sources/consumer form the master.
interface err_event_log_if #(
  parameter int NUM_CH = 4,
  parameter int CODE_W = 4,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16,
  parameter int DROP_W = 16
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ENT_W = TS_W + CH_W + CODE_W;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0]        ev_valid;
  logic [NUM_CH*CODE_W-1:0] ev_code;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [ENT_W-1:0]         rd_data;
  logic [LVL_W-1:0]         level;
  logic [NUM_CH-1:0]        ovf_sticky;
  logic [DROP_W-1:0]        drop_cnt;
  logic                     clr;

  modport master (
    output ev_valid, ev_code, rd_ready, clr,
    input  rd_valid, rd_data, level, ovf_sticky, drop_cnt
  );

  modport slave (
    input  ev_valid, ev_code, rd_ready, clr,
    output rd_valid, rd_data, level, ovf_sticky, drop_cnt
  );
endinterface

// File: rtl/err_event_log.sv
// Timestamped error event logger: per-channel holding slots, round-robin
// arbitration into an event FIFO, sticky per-channel drop flags and a drop counter.
module err_event_log #(
  parameter int NUM_CH = 4,
  parameter int CODE_W = 4,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16,
  parameter int DROP_W = 16
) (
  input  logic           clk,
  input  logic           arst_n,
  err_event_log_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ENT_W = TS_W + CH_W + CODE_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int DC_W  = $clog2(NUM_CH + 1);

  logic [TS_W-1:0]   ts_r;
  logic [TS_W-1:0]   slot_ts_r   [NUM_CH];
  logic [CODE_W-1:0] slot_code_r [NUM_CH];
  logic [NUM_CH-1:0] slot_busy_r;
  logic [CH_W-1:0]   rr_ptr_r;
  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              rd_valid_r;
  logic [ENT_W-1:0]  rd_data_r;
  logic [NUM_CH-1:0] ovf_r;
  logic [DROP_W-1:0] drop_cnt_r;

  logic              pop_s;
  logic              space_s;
  logic              gnt_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic [CH_W-1:0]   cand_s;
  logic [CH_W-1:0]   rr_nxt_s;
  logic [NUM_CH-1:0] gnt_vec_s;
  logic [NUM_CH-1:0] load_vec_s;
  logic [NUM_CH-1:0] drop_vec_s;
  logic [ENT_W-1:0]  push_data_s;
  logic [ENT_W-1:0]  head_nxt_s;
  logic [LVL_W-1:0]  level_nxt_s;
  logic [LVL_W-1:0]  level_left_s;
  logic [AW-1:0]     rd_ptr_nxt_s;
  logic [DC_W-1:0]   drop_num_s;
  logic [DROP_W:0]   drop_sum_s;
  logic [DROP_W-1:0] drop_cnt_nxt_s;

  // FIFO space: a full FIFO still accepts a push when the head leaves this cycle
  always_comb begin
    pop_s   = rd_valid_r & bus.rd_ready;
    space_s = (level_r < LVL_W'(DEPTH)) | pop_s;
  end

  // Round-robin search starting at the channel after the last grant
  always_comb begin
    gnt_s     = 1'b0;
    gnt_idx_s = '0;
    cand_s    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_s    = CH_W'((int'(rr_ptr_r) + i) % NUM_CH);
      gnt_idx_s = (!gnt_s && slot_busy_r[cand_s] && space_s) ? cand_s : gnt_idx_s;
      gnt_s     = gnt_s | (slot_busy_r[cand_s] & space_s);
    end
    rr_nxt_s    = (int'(gnt_idx_s) == NUM_CH - 1) ? '0 : gnt_idx_s + CH_W'(1);
    push_data_s = {slot_ts_r[gnt_idx_s], gnt_idx_s, slot_code_r[gnt_idx_s]};
  end

  // Slot load/drop decisions; a slot being granted this cycle can take a new event
  always_comb begin
    gnt_vec_s  = '0;
    load_vec_s = '0;
    drop_vec_s = '0;
    drop_num_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_vec_s[i]  = gnt_s && (gnt_idx_s == CH_W'(i));
      load_vec_s[i] = bus.ev_valid[i] & (~slot_busy_r[i] | gnt_vec_s[i]);
      drop_vec_s[i] = bus.ev_valid[i] & slot_busy_r[i] & ~gnt_vec_s[i];
      drop_num_s    = drop_num_s + DC_W'(drop_vec_s[i]);
    end
    drop_sum_s     = {1'b0, drop_cnt_r} + (DROP_W + 1)'(drop_num_s);
    drop_cnt_nxt_s = drop_sum_s[DROP_W] ? '1 : drop_sum_s[DROP_W-1:0];
  end

  // Next occupancy and next head entry, so rd_data can be a plain register
  always_comb begin
    level_nxt_s  = level_r + LVL_W'(gnt_s) - LVL_W'(pop_s);
    level_left_s = level_r - LVL_W'(pop_s);
    rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
    if (level_nxt_s == '0) begin
      head_nxt_s = '0;
    end else if (gnt_s && (level_left_s == '0)) begin
      head_nxt_s = push_data_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Timestamp counter and per-channel holding slots
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ts_r        <= '0;
      slot_busy_r <= '0;
      rr_ptr_r    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        slot_ts_r[i]   <= '0;
        slot_code_r[i] <= '0;
      end
    end else begin
      ts_r        <= ts_r + TS_W'(1);
      slot_busy_r <= load_vec_s | (slot_busy_r & ~gnt_vec_s);
      rr_ptr_r    <= gnt_s ? rr_nxt_s : rr_ptr_r;
      for (int i = 0; i < NUM_CH; i++) begin
        if (load_vec_s[i]) begin
          slot_ts_r[i]   <= ts_r;
          slot_code_r[i] <= bus.ev_code[i*CODE_W +: CODE_W];
        end
      end
    end
  end

  // Event FIFO storage, pointers and registered head
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (gnt_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r   <= rd_ptr_nxt_s;
      level_r    <= level_nxt_s;
      rd_valid_r <= (level_nxt_s != '0);
      rd_data_r  <= head_nxt_s;
    end
  end

  // Drop status; clear wins over drops in the same cycle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_r      <= '0;
      drop_cnt_r <= '0;
    end else begin
      ovf_r      <= bus.clr ? '0 : (ovf_r | drop_vec_s);
      drop_cnt_r <= bus.clr ? '0 : drop_cnt_nxt_s;
    end
  end

  assign bus.rd_valid   = rd_valid_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.level      = level_r;
  assign bus.ovf_sticky = ovf_r;
  assign bus.drop_cnt   = drop_cnt_r;
endmodule

// File: tb/tb_err_event_log.sv
// Directed bench for err_event_log: expected entries are queued at stimulus
// time and a monitor compares every accepted read against the queue head.
module tb_err_event_log;
  localparam int NUM_CH = 4;
  localparam int CODE_W = 4;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 16;
  localparam int DROP_W = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  err_event_log_if #(.NUM_CH(NUM_CH), .CODE_W(CODE_W), .DEPTH(DEPTH),
                     .TS_W(TS_W), .DROP_W(DROP_W)) bus ();

  err_event_log #(.NUM_CH(NUM_CH), .CODE_W(CODE_W), .DEPTH(DEPTH),
                  .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] m_ts;
  logic [21:0] exp_q [$];

  // Reference timestamp: value the DUT counter holds during the current cycle
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) m_ts <= 16'h0000;
    else         m_ts <= m_ts + 16'h0001;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: an accepted head must match the oldest expected entry
  always @(negedge clk) begin
    logic [21:0] e;
    if (arst_n === 1'b1 && bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry got=%h want=none", bus.rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("fifo_entry", 32'(bus.rd_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_exp(input logic [1:0] ch, input logic [3:0] code);
    exp_q.push_back({m_ts, ch, code});
  endfunction

  task automatic fire(input logic [3:0] v, input logic [15:0] codes);
    bus.ev_valid = v;
    bus.ev_code  = codes;
    tick();
    bus.ev_valid = 4'b0000;
    bus.ev_code  = 16'h0000;
  endtask

  task automatic wait_empty(input string nm, input int limit);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < limit) begin
      tick();
      g++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] e12;
    int g;
    bus.ev_valid = 4'b0000;
    bus.ev_code  = 16'h0000;
    bus.rd_ready = 1'b0;
    bus.clr      = 1'b0;
    arst_n       = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_data", 32'(bus.rd_data), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    chk("rst_ovf", 32'(bus.ovf_sticky), 32'd0);
    arst_n = 1'b1;

    // Single event on ch2 at ts 0x0010, two-cycle latency
    bus.rd_ready = 1'b1;
    g = 0;
    while (m_ts != 16'h0010 && g < 64) begin
      tick();
      g++;
    end
    push_exp(2'd2, 4'h5);
    fire(4'b0100, 16'h0500);
    chk("lat1_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("lat2_valid", 32'(bus.rd_valid), 32'd1);
    chk("single_data", 32'(bus.rd_data), 32'({16'h0010, 2'd2, 4'h5}));
    chk("single_level", 32'(bus.level), 32'd1);
    repeat (3) tick();
    chk("idle_level", 32'(bus.level), 32'd0);
    chk("idle_valid", 32'(bus.rd_valid), 32'd0);
    chk("single_seen", 32'(exp_q.size()), 32'd0);

    // Contention right after reset: grant order ch0..ch3, same ts
    pulse_reset();
    bus.rd_ready = 1'b1;
    tick();
    push_exp(2'd0, 4'h1);
    push_exp(2'd1, 4'h2);
    push_exp(2'd2, 4'h3);
    push_exp(2'd3, 4'h4);
    fire(4'b1111, 16'h4321);
    wait_empty("contention_drain", 12);
    chk("contention_drop", 32'(bus.drop_cnt), 32'd0);
    chk("contention_ovf", 32'(bus.ovf_sticky), 32'd0);

    // Backpressure: 12 back-to-back ch1 events, 8 queued + 1 held + 3 dropped
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k <= 8) push_exp(2'd1, 4'(k));
      fire(4'b0010, {8'h00, 4'(k), 4'h0});
    end
    tick();
    chk("bp_level", 32'(bus.level), 32'd8);
    chk("bp_drop", 32'(bus.drop_cnt), 32'd3);
    chk("bp_ovf", 32'(bus.ovf_sticky), 32'h2);
    chk("bp_head", 32'(bus.rd_data), 32'(exp_q[0]));
    tick();
    chk("bp_hold_valid", 32'(bus.rd_valid), 32'd1);
    chk("bp_hold_data", 32'(bus.rd_data), 32'(exp_q[0]));
    bus.rd_ready = 1'b1;
    wait_empty("bp_drain", 30);
    tick();
    chk("bp_empty_level", 32'(bus.level), 32'd0);

    // Full FIFO with busy slot: simultaneous pop and push keep level at 8
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      push_exp(2'd0, 4'(k));
      fire(4'b0001, {12'h000, 4'(k)});
    end
    chk("full_level", 32'(bus.level), 32'd8);
    bus.rd_ready = 1'b1;
    e12 = '0;
    for (int k = 9; k < 13; k++) begin
      if (k < 12) push_exp(2'd0, 4'(k));
      else        e12 = {m_ts, 2'd0, 4'hC};
      fire(4'b0001, {12'h000, 4'(k)});
      chk("fullpp_level", 32'(bus.level), 32'd8);
    end
    bus.rd_ready = 1'b0;
    chk("fullpp_nodrop", 32'(bus.drop_cnt), 32'd3);

    // ch3 captured while full, then dropped; clr wins over a same-cycle drop
    push_exp(2'd3, 4'hA);
    fire(4'b1000, 16'hA000);
    fire(4'b1000, 16'hB000);
    chk("drop3_cnt", 32'(bus.drop_cnt), 32'd4);
    chk("drop3_ovf", 32'(bus.ovf_sticky), 32'hA);
    bus.clr = 1'b1;
    fire(4'b1000, 16'hC000);
    bus.clr = 1'b0;
    chk("clr_drop", 32'(bus.drop_cnt), 32'd0);
    chk("clr_ovf", 32'(bus.ovf_sticky), 32'd0);
    chk("clr_level", 32'(bus.level), 32'd8);
    // rr pointer sits after ch0, so held ch3 goes out before held ch0
    exp_q.push_back(e12);
    bus.rd_ready = 1'b1;
    wait_empty("full_drain", 30);
    tick();
    chk("full_empty_level", 32'(bus.level), 32'd0);

    // Reset mid-stream discards queued events; ts restarts at 0
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fire(4'b0100, {4'h0, 4'(k), 8'h00});
    end
    tick();
    tick();
    chk("mid_level", 32'(bus.level), 32'd5);
    #2;
    arst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_level", 32'(bus.level), 32'd0);
    chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
    tick();
    arst_n = 1'b1;
    bus.rd_ready = 1'b1;
    push_exp(2'd1, 4'h7);
    fire(4'b0010, 16'h0070);
    chk("post_lat1_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("post_lat2_valid", 32'(bus.rd_valid), 32'd1);
    chk("post_data", 32'(bus.rd_data), 32'({16'h0000, 2'd1, 4'h7}));
    repeat (3) tick();
    chk("post_seen", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/err_event_log.md
ERR_EVENT_LOG -- requirements
Module: err_event_log

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent error-code sources.
REQ-002 Parameter CODE_W, default 4: error code width per channel.
REQ-003 Parameter DEPTH, default 8: event FIFO depth, power of 2, >=2.
REQ-004 Parameter TS_W, default 16: timestamp width.
REQ-005 Parameter DROP_W, default 16: drop counter width; CH_W = max(1,$clog2(NUM_CH)); ENT_W = TS_W+CH_W+CODE_W.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 arst_n  in  1  asynchronous active-low reset.
REQ-008 ev_valid  in  NUM_CH  one-cycle event strobe per channel.
REQ-009 ev_code  in  NUM_CH*CODE_W  channel i code at bits [i*CODE_W +: CODE_W]; sampled only when ev_valid[i]=1.
REQ-010 rd_valid  out  1  FIFO head entry available.
REQ-011 rd_ready  in  1  consumer accepts head; pop when rd_valid&&rd_ready.
REQ-012 rd_data  out  ENT_W  head entry {ts, ch, code}, ts in MSBs.
REQ-013 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 ovf_sticky  out  NUM_CH  per-channel sticky drop flag.
REQ-015 drop_cnt  out  DROP_W  saturating total dropped events.
REQ-016 clr  in  1  synchronous clear of ovf_sticky and drop_cnt.

Function
REQ-017 Free-running ts counter SHALL increment by 1 every cycle, wrapping from all-ones to 0.
REQ-018 Each channel SHALL own a one-entry holding slot {ts, code, busy}.
REQ-019 ev_valid[i] SHALL load slot i with the current-cycle ts and ev_code[i] when slot i is not busy, or is busy but granted in the same cycle.
REQ-020 Otherwise the event SHALL be dropped: ovf_sticky[i] set, slot contents unchanged.
REQ-021 drop_cnt SHALL add the number of channels dropping in that cycle, saturating at all-ones.
REQ-022 clr SHALL have priority: in a clr cycle ovf_sticky and drop_cnt become 0 regardless of same-cycle drops.
REQ-023 Arbiter SHALL grant at most one busy slot per cycle, round-robin, searching from (last granted channel + 1) mod NUM_CH.
REQ-024 Grant SHALL occur only when FIFO has space: level<DEPTH, or level==DEPTH with pop in the same cycle.
REQ-025 Granted slot SHALL be written to FIFO as {slot ts, channel index, slot code} and cleared at the same edge.
REQ-026 Latency: event in cycle N, slot idle, no contention, FIFO empty -> rd_valid=1 in cycle N+2 with ts equal to ts value in cycle N.
REQ-027 FIFO full and no pop: no grant; slots hold contents (no loss of already-captured events).
REQ-028 Simultaneous push and pop SHALL leave level unchanged, at any level including 0 (no pop when empty) and DEPTH.
REQ-029 rd_data and rd_valid SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-030 Entries SHALL leave the FIFO in push order; pointers wrap modulo DEPTH.
REQ-031 rd_ready while rd_valid=0 SHALL have no effect.

Reset
REQ-032 arst_n low SHALL asynchronously clear ts, all slots, FIFO pointers, level, ovf_sticky, drop_cnt; rd_valid=0, rd_data=0.
REQ-033 After reset the round-robin pointer SHALL make channel 0 the highest-priority candidate.
REQ-034 Reset asserted mid-operation SHALL discard all held and queued events; first post-reset event follows REQ-026.

Verification (NUM_CH=4, CODE_W=4, DEPTH=8, TS_W=16)
REQ-035 Single event: reset released, ev_valid=4'b0100, ch2 code 4'h5 at ts=0x0010 -> cycle+2 rd_valid=1, rd_data={16'h0010,2'd2,4'h5}, level=1.
REQ-036 Contention: ev_valid=4'b1111 codes 1,2,3,4 in one cycle -> 4 entries read out in order ch0,ch1,ch2,ch3, identical ts, no drops.
REQ-037 Backpressure: rd_ready=0, 12 events on ch1 spaced 1 per cycle -> level=8, 1 held in slot, remaining 3 dropped: drop_cnt=3, ovf_sticky=4'b0010; then drain -> 9 entries total, in order.
REQ-038 Full push/pop: level=8, rd_ready=1 with slot busy -> level stays 8 each cycle, entry accepted, no drop.
REQ-039 Clear priority: clr=1 in same cycle as a ch3 drop -> next cycle drop_cnt=0, ovf_sticky=0.
REQ-040 Reset mid-stream: level=5, arst_n pulsed low -> level=0, rd_valid=0, drop_cnt=0; next event appears in 2 cycles with ts counted from 0.
